// File: rtl/karatsuba_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | karatsuba_pkg: shared FSM encodings and step constants           |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package karatsuba_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned STEPS     = 4;
  localparam logic [1:0]  STEP_LAST = 2'(STEPS - 1);

  // Step 0 -> lo*lo, steps 1/2 -> cross terms, step 3 -> hi*hi.
  function automatic logic [3:0] step_shift(input logic [1:0] step);
    case (step)
      2'd0:    step_shift = 4'd0;
      2'd1,
      2'd2:    step_shift = 4'd4;
      default: step_shift = 4'd8;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/karatsuba_mul_4.sv
`default_nettype none
// +------------------------------------------------------------------+
// | karatsuba_mul_4: combinational 4x4 unsigned Karatsuba multiplier |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module karatsuba_mul_4 (
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic [7:0] p
);

  logic [1:0] xh, xl, yh, yl;
  logic [2:0] xs, ys;
  logic [3:0] z0, z2;
  logic [5:0] zm, z1;

  always_comb begin
    xh = x[3:2];
    xl = x[1:0];
    yh = y[3:2];
    yl = y[1:0];
    z0 = {2'b00, xl} * {2'b00, yl};
    z2 = {2'b00, xh} * {2'b00, yh};
    xs = {1'b0, xh} + {1'b0, xl};
    ys = {1'b0, yh} + {1'b0, yl};
    zm = {3'b000, xs} * {3'b000, ys};
    // Middle term xh*yl + xl*yh recovered from the single sum product.
    z1 = zm - {2'b00, z0} - {2'b00, z2};
    p  = {z2, 4'b0000} + {z1, 2'b00} + {4'b0000, z0};
  end

endmodule
`default_nettype wire

// File: rtl/karatsuba_mul_seq_8.sv
`default_nettype none
// +------------------------------------------------------------------+
// | karatsuba_mul_seq_8: 8x8 unsigned multiplier, one 4x4 per cycle  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module karatsuba_mul_seq_8
  import karatsuba_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] c
);

  state_t      state_q, state_d;
  logic [1:0]  step_q, step_d;
  logic [15:0] acc_q, acc_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;

  logic [3:0]  x_sel, y_sel;
  logic [7:0]  pp;

  // Step bit 0 picks the multiplicand nibble, bit 1 the multiplier nibble.
  always_comb begin
    x_sel = step_q[0] ? a_q[7:4] : a_q[3:0];
    y_sel = step_q[1] ? b_q[7:4] : b_q[3:0];
  end

  karatsuba_mul_4 u_mul4 (
    .x (x_sel),
    .y (y_sel),
    .p (pp)
  );

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d     = a;
          b_d     = b;
          acc_d   = 16'h0000;
          step_d  = 2'd0;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d = acc_q + ({8'h00, pp} << step_shift(step_q));
        if (step_q == STEP_LAST) begin
          state_d = DONE;
        end else begin
          step_d = step_q + 2'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      step_q      <= 2'd0;
      acc_q       <= 16'h0000;
      a_q         <= 8'h00;
      b_q         <= 8'h00;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      acc_q       <= acc_d;
      a_q         <= a_d;
      b_q         <= b_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign c         = acc_q;

endmodule
`default_nettype wire

// File: tb/tb_karatsuba_mul_seq_8.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_karatsuba_mul_seq_8: directed vectors plus handshake corners  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_karatsuba_mul_seq_8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] c;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] c;
  } vec_t;

  vec_t vecs [8];

  karatsuba_mul_seq_8 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c         (c)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transaction; inputs scrambled while busy, optional stall in DONE.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v,
                        input logic [15:0] exp, input int stall);
    int n;
    int lat;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    chk("ready_before_op", in_ready, 1);
    a         = ta;
    b         = tb_v;
    in_valid  = 1'b1;
    out_ready = (stall == 0);
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      chk("busy_in_ready", in_ready, 0);
      a = 8'($urandom);
      b = 8'($urandom);
      tick();
      lat++;
    end
    chk("latency", lat, 4);
    chk("product", c, exp);
    for (int i = 0; i < stall; i++) begin
      chk("stall_out_valid", out_valid, 1);
      chk("stall_c", c, exp);
      chk("stall_in_ready", in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("release_out_valid", out_valid, 0);
    chk("release_in_ready", in_ready, 1);
  endtask

  initial begin
    int          n;
    int          lat;
    int          prev_acc;
    logic [7:0]  ea, eb;
    logic [15:0] e;

    vecs[0] = '{8'h12, 8'h34, 16'h03A8};
    vecs[1] = '{8'hFF, 8'hFF, 16'hFE01};
    vecs[2] = '{8'h00, 8'hAB, 16'h0000};
    vecs[3] = '{8'h01, 8'h01, 16'h0001};
    vecs[4] = '{8'h0F, 8'hF0, 16'h0E10};
    vecs[5] = '{8'hF0, 8'hF0, 16'hE100};
    vecs[6] = '{8'h80, 8'h02, 16'h0100};
    vecs[7] = '{8'hAA, 8'h55, 16'h3872};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = 8'h5A;
    b         = 8'hC3;
    #23;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_c", c, 16'h0000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // First vector issued so it is accepted on the first edge after release.
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].c, 0);
    end

    run_op(8'hA5, 8'h3C, 16'h26AC, 10);

    // Reset while step 2 is pending.
    a        = 8'hA5;
    b        = 8'h3C;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("midreset_out_valid", out_valid, 0);
    chk("midreset_c", c, 16'h0000);
    chk("midreset_in_ready", in_ready, 1);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("abandoned_out_valid", out_valid, 0);
      tick();
    end
    run_op(8'h07, 8'h09, 16'h003F, 0);

    // Back-to-back with in_valid and out_ready held high.
    in_valid  = 1'b1;
    out_ready = 1'b1;
    prev_acc  = 0;
    for (int i = 0; i < 100; i++) begin
      ea = 8'($urandom);
      eb = 8'($urandom);
      e  = ea * eb;
      a  = ea;
      b  = eb;
      tick();
      if (i > 0) chk("b2b_period", cyc - prev_acc, 6);
      prev_acc = cyc;
      lat = 0;
      while (!out_valid && lat < 20) begin
        a = 8'($urandom);
        b = 8'($urandom);
        tick();
        lat++;
      end
      chk("b2b_latency", lat, 4);
      chk("b2b_product", c, e);
      tick();
      chk("b2b_idle", in_ready, 1);
    end
    in_valid = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
